alu_seq: RTL and testbench
==========================

# alu_seq

Multi-precision arithmetic sequencer for the 8-bit ALU. It accepts an NBYTES-wide add/subtract command, then drives the ALU one byte per clock from LSB to MSB, chaining the carry through a register. It collects the result bytes, final carry/borrow and a whole-word zero flag. It sits between the CPU/control path and a single shared ALU instance, and owns the ALU's a, b, carry and op inputs.

## Interface
- NBYTES, 4: operand width in bytes (≥1); word width W = 8*NBYTES.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- cmd  in  2  0=ADD, 1=ADC (add + cin), 2=SUB, 3=SBB (subtract − cin as borrow).
- cin  in  1  carry/borrow in; used by ADC/SBB only.
- opa  in  W  operand A; latched on accepted start.
- opb  in  W  operand B; latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result, cout and zero are valid.
- result  out  W  A±B; held until the next accepted start.
- cout  out  1  ADD/ADC: carry out of the MSB. SUB/SBB: borrow (1 = A < B + cin).
- zero  out  1  result == 0 over all W bits.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_carry  out  1  to ALU carry.
- alu_op  out  4  to ALU op.
- alu_c  in  8  from ALU c.
- alu_cout  in  1  from ALU carry_out.
- alu_zero  in  1  from ALU zero.

## Operation
- FSM states and transitions:
  - IDLE → RUN on start=1.
  - RUN → DONE after byte NBYTES−1 is captured.
  - DONE → IDLE unconditionally.
- On an accepted start, latch opa/opb and set the byte index i=0.
  - For SUB/SBB, latch B as ~opb.
  - Set the carry register: ADD 0; ADC cin; SUB 1; SBB ~cin.
- Subtraction uses only ALU add opcodes, computing A + ~B + carry.
  - ALU opcodes 2 and 3 are never issued.
- RUN byte i drives the ALU combinationally from registers:
  - alu_a = A[8i+7:8i] and alu_b = Bq[8i+7:8i].
  - alu_carry = carry register.
  - alu_op = 4'd0 when (i==0 and cmd==ADD), otherwise 4'd1 (ADC).
    - Byte 0 of ADD therefore uses op 0 with alu_carry=0.
- Each RUN edge:
  - result[8i+7:8i] ← alu_c.
  - carry register ← alu_cout.
  - zero accumulator ← zacc & alu_zero; the accumulator is set to 1 at start.
  - i ← i+1.
- At the last byte:
  - cout ← alu_cout for ADD/ADC, ~alu_cout for SUB/SBB.
  - zero ← zacc & alu_zero.
- Outside RUN, the ALU is driven idle: alu_a=0, alu_b=0, alu_carry=0, alu_op=4'd4 (pass A).
- start is ignored in RUN and DONE (no queueing), and cin/opa/opb changes after acceptance have no effect.
- Arithmetic is modulo 2^W; no overflow flag.

## Timing
- Reset (rst=1 at an edge):
  - State → IDLE; i=0.
  - busy=0, done=0, result=0, cout=0, zero=0.
  - ALU outputs at idle values from the next cycle.
  - Reset wins over start in the same cycle.
  - Reset mid-RUN aborts the command with no done pulse.
- With start accepted at edge E0:
  - busy=1 in cycles E0..E0+NBYTES−1 (byte i processed in the cycle after edge E0+i).
  - done=1 for exactly the one cycle after edge E0+NBYTES; busy=0 in that cycle.
  - Latency from start to done is NBYTES+1 cycles; throughput is one command per NBYTES+2 cycles.
- result, cout and zero change only at RUN edges and reset.
  - Intermediate bytes are visible during RUN; they are valid only when done=1 and thereafter until the next start.
- NBYTES=1 behaves as a single RUN cycle; done follows 2 edges after start.

## Test plan
- NBYTES=4, ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, cout=1, zero=1. done exactly 5 cycles after start; alu_op sequence 0,1,1,1.
- SUB 0x00000000 − 0x00000001 → result 0xFFFFFFFF, cout=1 (borrow), zero=0. Byte 0 sees alu_b=0xFE, alu_carry=1.
- SUB 0x12345678 − 0x12345678 → result 0, cout=0, zero=1. Then SBB with same operands and cin=1 → 0xFFFFFFFF, cout=1, zero=0.
- ADC 0x000000FF + 0x00000000 with cin=1 → result 0x00000100, cout=0, zero=0. ADD 0x80000000 + 0x80000000 → result 0, cout=1, zero=1.
- start pulsed during RUN and during DONE (opa changed) → ignored; the first command's result is unchanged and there is exactly one done pulse.
- rst asserted in the 2nd RUN cycle → next cycle busy=0, done=0, result=0, alu_op=4; no done follows. A fresh ADD 3+4 → 7, cout=0, zero=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-precision add/subtract sequencer for a shared 8-bit ALU.
// It takes an NBYTES-wide command and drives the ALU one byte per clock,
// from LSB to MSB. The carry is chained through a register between bytes.
// At the end it reports the full result, the final carry or borrow, and a
// whole-word zero flag.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start, cmd, cin command strobe (taken in IDLE only), opcode, carry/borrow in
//   opa, opb        W-bit operands, latched when start is accepted
//   busy, done      busy is high in RUN; done is a one-cycle result-valid pulse
//   result, cout    A+/-B, and carry out (ADD/ADC) or borrow (SUB/SBB)
//   zero            result == 0 over all W bits
//   alu_a, alu_b, alu_carry, alu_op   driven to the ALU from registers
//   alu_c, alu_cout, alu_zero         returned by the ALU
module alu_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_carry,
  output logic [3:0]            alu_op,
  input  logic [7:0]            alu_c,
  input  logic                  alu_cout,
  input  logic                  alu_zero
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  localparam logic [1:0] CMD_ADD = 2'd0;
  localparam logic [1:0] CMD_ADC = 2'd1;
  localparam logic [1:0] CMD_SUB = 2'd2;
  localparam logic [1:0] CMD_SBB = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADC  = 4'd1;
  localparam logic [3:0] ALU_PASS = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;      // holds ~opb for SUB/SBB
  logic [NBYTES-1:0][7:0] result_q;
  logic [1:0]             cmd_q;
  logic [IDX_W-1:0]       idx;
  logic                   carry_q;
  logic                   zacc;
  logic                   cout_q;
  logic                   zero_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   carry_init;
  logic                   accept;

  assign accept = (state == IDLE) && start;

  // Initial carry: subtraction is A + ~B + 1, and a borrow-in removes the +1
  always_comb begin
    carry_init = 1'b0;
    case (cmd)
      CMD_ADD: carry_init = 1'b0;
      CMD_ADC: carry_init = cin;
      CMD_SUB: carry_init = 1'b1;
      CMD_SBB: carry_init = ~cin;
      default: carry_init = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (idx == LAST_IDX) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ALU drive: the current byte while in RUN, otherwise idle pass-A with zeros
  always_comb begin
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    alu_carry = 1'b0;
    alu_op    = ALU_PASS;
    if (state == RUN) begin
      alu_a     = a_q[idx];
      alu_b     = b_q[idx];
      alu_carry = carry_q;
      alu_op    = ((idx == '0) && (cmd_q == CMD_ADD)) ? ALU_ADD : ALU_ADC;
    end
  end

  // Operand latch, byte walk, and result/flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cmd_q    <= CMD_ADD;
      idx      <= '0;
      carry_q  <= 1'b0;
      zacc     <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= opa;
      b_q     <= cmd[1] ? ~opb : opb;
      cmd_q   <= cmd;
      idx     <= '0;
      carry_q <= carry_init;
      zacc    <= 1'b1;
    end else if (state == RUN) begin
      result_q[idx] <= alu_c;
      carry_q       <= alu_cout;
      zacc          <= zacc & alu_zero;
      if (idx == LAST_IDX) begin
        // For subtraction, the ALU carry out is the inverse of the borrow
        cout_q <= alu_cout ^ cmd_q[1];
        zero_q <= zacc & alu_zero;
        idx    <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Status flops follow the next state, so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_n == RUN);
      done_q <= (state_n == DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: checks alu_seq against a behavioural 8-bit ALU, using directed
// commands whose expected results were worked out by hand. Expected
// {result, cout, zero} tuples go into a queue when a command is issued. A
// monitor pops one tuple on every done pulse and compares it with the outputs.
module tb_alu_seq;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    cmd;
  logic          cin;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic          zero;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic          alu_carry;
  logic [3:0]    alu_op;
  logic [7:0]    alu_c;
  logic          alu_cout;
  logic          alu_zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   done_cnt = 0;

  logic [3:0] op_seq   [NBYTES];
  logic [7:0] b_seq    [NBYTES];
  logic       carry_seq[NBYTES];

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd       (cmd),
    .cin       (cin),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_carry (alu_carry),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_cout  (alu_cout),
    .alu_zero  (alu_zero)
  );

  // Shared 8-bit ALU: op 0 add, op 1 add with carry, op 4 pass A
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'd0;
    case (alu_op)
      4'd0:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_carry);
      4'd4:    alu_sum = {1'b0, alu_a};
      default: alu_sum = 9'd0;
    endcase
  end
  assign alu_c    = alu_sum[7:0];
  assign alu_cout = alu_sum[8];
  assign alu_zero = (alu_sum[7:0] == 8'd0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse consumes one expected tuple
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("cout",   64'(cout),   64'(e.co));
        chk("zero",   64'(zero),   64'(e.z));
      end
    end
  end

  // Issue one command, record the per-byte ALU drive, and check busy/done timing
  task automatic run_cmd(input logic [1:0] c, input logic ci,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input logic ez);
    @(negedge clk);
    start = 1'b1; cmd = c; cin = ci; opa = a; opb = b;
    exp_q.push_back({er, ec, ez});
    @(negedge clk);
    // Changes after acceptance must have no effect
    start = 1'b0; cin = ~ci; opa = ~a; opb = ~b;
    for (int k = 0; k < NBYTES; k++) begin
      op_seq[k]    = alu_op;
      b_seq[k]     = alu_b;
      carry_seq[k] = alu_carry;
      chk("busy_run", 64'(busy), 64'(1));
      @(negedge clk);
    end
    chk("done_latency", 64'(done), 64'(1));
    chk("busy_in_done", 64'(busy), 64'(0));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; cmd = 2'd0; cin = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   64'(busy),   64'(0));
    chk("rst_done",   64'(done),   64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_cout",   64'(cout),   64'(0));
    chk("rst_zero",   64'(zero),   64'(0));
    chk("rst_alu_op", 64'(alu_op), 64'(4));
    chk("rst_alu_a",  64'(alu_a),  64'(0));
    rst = 1'b0;

    // ADD all-ones + 1 wraps to zero with carry out
    run_cmd(2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
    chk("add_op0", 64'(op_seq[0]), 64'(0));
    chk("add_op1", 64'(op_seq[1]), 64'(1));
    chk("add_op2", 64'(op_seq[2]), 64'(1));
    chk("add_op3", 64'(op_seq[3]), 64'(1));

    // SUB 0 - 1 borrows across the whole word
    run_cmd(2'd2, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("sub_b0",     64'(b_seq[0]),     64'(8'hFE));
    chk("sub_carry0", 64'(carry_seq[0]), 64'(1));
    chk("sub_op0",    64'(op_seq[0]),    64'(1));

    run_cmd(2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1);
    run_cmd(2'd3, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("sbb_carry0", 64'(carry_seq[0]), 64'(0));
    run_cmd(2'd1, 1'b1, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0100, 1'b0, 1'b0);
    chk("adc_carry0", 64'(carry_seq[0]), 64'(1));
    run_cmd(2'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);

    // start pulsed in RUN and in DONE is ignored
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; cmd = 2'd0; cin = 1'b0; opa = 32'h0000_1000; opb = 32'h0000_0234;
    exp_q.push_back({32'h0000_1234, 1'b0, 1'b0});
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; opa = 32'hFFFF_FFFF;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("done_cycle", 64'(done), 64'(1));
    start = 1'b1; opa = 32'h0000_0000;
    @(negedge clk); start = 1'b0;
    chk("start_in_done_ignored", 64'(busy), 64'(0));
    repeat (8) @(negedge clk);
    chk("single_done_pulse", 64'(done_cnt - d0), 64'(1));
    chk("result_held", 64'(result), 64'(32'h0000_1234));

    // Reset in the second RUN cycle aborts with no done
    @(negedge clk);
    start = 1'b1; cmd = 2'd0; opa = 32'h1111_1111; opb = 32'h2222_2222;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    chk("abort_busy",   64'(busy),   64'(0));
    chk("abort_done",   64'(done),   64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_alu_op", 64'(alu_op), 64'(4));
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));

    run_cmd(2'd0, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("all_done_seen", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
